// File: rtl/butterfly_seq.sv
// Radix-2 DIT butterfly with a shared pair of multipliers: X = A + W'B, Y = A - W'B.
// Five-state sequencer, round-half-up twiddle scaling, optional halving, saturation with sticky flag.
module butterfly_seq #(
    parameter int unsigned data_width = 16,
    parameter int unsigned frac_bits  = 8
) (
    input  logic                  clk_MAC,
    input  logic                  aclr,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  inverse,
    input  logic                  scale,
    input  logic [data_width-1:0] A_real,
    input  logic [data_width-1:0] A_imag,
    input  logic [data_width-1:0] B_real,
    input  logic [data_width-1:0] B_imag,
    input  logic [data_width-1:0] W_real,
    input  logic [data_width-1:0] W_imag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [data_width-1:0] X_real,
    output logic [data_width-1:0] X_imag,
    output logic [data_width-1:0] Y_real,
    output logic [data_width-1:0] Y_imag,
    output logic                  ovf,
    input  logic                  ovf_clr
);

    localparam int unsigned DW = data_width;
    localparam int unsigned PW = 2 * DW;
    localparam int unsigned AW = PW + 1;
    localparam int unsigned SW = DW + 3;

    localparam logic signed [AW-1:0] RND_HALF = AW'(64'd1 << (frac_bits - 1));
    // P is clamped to DW+2 bits; any clamped value saturates the result anyway
    localparam logic signed [AW-1:0] P_MAX    = AW'((64'd1 << (DW + 1)) - 64'd1);
    localparam logic signed [AW-1:0] P_MIN    = ~P_MAX;
    localparam logic signed [SW-1:0] O_MAX    = SW'((64'd1 << (DW - 1)) - 64'd1);
    localparam logic signed [SW-1:0] O_MIN    = ~O_MAX;

    typedef enum logic [2:0] {IDLE, MAC0, MAC1, SUM, DONE} state_t;

    state_t state, state_d;

    logic signed [DW-1:0] a_re_q, a_im_q, b_re_q, b_im_q, w_re_q, w_im_q;
    logic                 inv_q, scale_q;
    logic signed [AW-1:0] acc_re, acc_im;

    logic                 accept;
    logic signed [DW-1:0] mul_b, mul_w0, mul_w1;
    logic signed [PW-1:0] prod0, prod1;
    logic signed [AW-1:0] rnd_re, rnd_im;
    logic signed [SW-1:0] p_re, p_im;
    logic        [DW:0]   sx_re, sx_im, sy_re, sy_im;
    logic                 sat_any;

    function automatic logic signed [SW-1:0] clamp_p(input logic signed [AW-1:0] v);
        if (v > P_MAX)      return SW'(P_MAX);
        else if (v < P_MIN) return SW'(P_MIN);
        else                return SW'(v);
    endfunction

    // Returns {saturated, value}
    function automatic logic [DW:0] scale_sat(input logic signed [SW-1:0] v, input logic half);
        logic signed [SW-1:0] t;
        t = half ? ((v + SW'(1)) >>> 1) : v;
        if (t > O_MAX)      return {1'b1, DW'(O_MAX)};
        else if (t < O_MIN) return {1'b1, DW'(O_MIN)};
        else                return {1'b0, DW'(t)};
    endfunction

    assign accept = in_valid & in_ready;

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (accept) state_d = MAC0;
            MAC0:    state_d = MAC1;
            MAC1:    state_d = SUM;
            SUM:     state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_MAC or posedge aclr) begin
        if (aclr) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_d;
            in_ready  <= (state_d == IDLE);
            out_valid <= (state_d == DONE);
        end
    end

    // MAC0 multiplies by B_real, MAC1 by B_imag with the twiddle halves swapped
    always_comb begin
        mul_b  = b_re_q;
        mul_w0 = w_re_q;
        mul_w1 = w_im_q;
        if (state == MAC1) begin
            mul_b  = b_im_q;
            mul_w0 = w_im_q;
            mul_w1 = w_re_q;
        end
        prod0 = PW'(mul_b) * PW'(mul_w0);
        prod1 = PW'(mul_b) * PW'(mul_w1);
    end

    always_comb begin
        rnd_re  = (acc_re + RND_HALF) >>> frac_bits;
        rnd_im  = (acc_im + RND_HALF) >>> frac_bits;
        p_re    = clamp_p(rnd_re);
        p_im    = clamp_p(rnd_im);
        sx_re   = scale_sat(SW'(a_re_q) + p_re, scale_q);
        sx_im   = scale_sat(SW'(a_im_q) + p_im, scale_q);
        sy_re   = scale_sat(SW'(a_re_q) - p_re, scale_q);
        sy_im   = scale_sat(SW'(a_im_q) - p_im, scale_q);
        sat_any = sx_re[DW] | sx_im[DW] | sy_re[DW] | sy_im[DW];
    end

    always_ff @(posedge clk_MAC or posedge aclr) begin
        if (aclr) begin
            a_re_q  <= '0;
            a_im_q  <= '0;
            b_re_q  <= '0;
            b_im_q  <= '0;
            w_re_q  <= '0;
            w_im_q  <= '0;
            inv_q   <= 1'b0;
            scale_q <= 1'b0;
            acc_re  <= '0;
            acc_im  <= '0;
            X_real  <= '0;
            X_imag  <= '0;
            Y_real  <= '0;
            Y_imag  <= '0;
            ovf     <= 1'b0;
        end else begin
            if (accept) begin
                a_re_q  <= A_real;
                a_im_q  <= A_imag;
                b_re_q  <= B_real;
                b_im_q  <= B_imag;
                w_re_q  <= W_real;
                w_im_q  <= W_imag;
                inv_q   <= inverse;
                scale_q <= scale;
            end
            // Conjugation folded into the sign of every W_imag product
            case (state)
                MAC0: begin
                    acc_re <= AW'(prod0);
                    acc_im <= inv_q ? -AW'(prod1) : AW'(prod1);
                end
                MAC1: begin
                    acc_re <= inv_q ? (acc_re + AW'(prod0)) : (acc_re - AW'(prod0));
                    acc_im <= acc_im + AW'(prod1);
                end
                SUM: begin
                    X_real <= sx_re[DW-1:0];
                    X_imag <= sx_im[DW-1:0];
                    Y_real <= sy_re[DW-1:0];
                    Y_imag <= sy_im[DW-1:0];
                end
                default: ;
            endcase
            ovf <= ((state == SUM) & sat_any) | (ovf & ~ovf_clr);
        end
    end

endmodule

// File: tb/tb_butterfly_seq.sv
// Directed bench for butterfly_seq: hand-computed butterflies, latency, saturation, handshake, reset.
module tb_butterfly_seq;

    logic               clk_MAC = 1'b0;
    logic               aclr;
    logic               in_valid, in_ready, inverse, scale;
    logic signed [15:0] A_real, A_imag, B_real, B_imag, W_real, W_imag;
    logic               out_valid, out_ready, ovf, ovf_clr;
    logic signed [15:0] X_real, X_imag, Y_real, Y_imag;

    int checks = 0;
    int errors = 0;

    butterfly_seq #(.data_width(16), .frac_bits(8)) dut (
        .clk_MAC  (clk_MAC),
        .aclr     (aclr),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .inverse  (inverse),
        .scale    (scale),
        .A_real   (A_real),
        .A_imag   (A_imag),
        .B_real   (B_real),
        .B_imag   (B_imag),
        .W_real   (W_real),
        .W_imag   (W_imag),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .X_real   (X_real),
        .X_imag   (X_imag),
        .Y_real   (Y_real),
        .Y_imag   (Y_imag),
        .ovf      (ovf),
        .ovf_clr  (ovf_clr)
    );

    always #5 clk_MAC = ~clk_MAC;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_MAC);
        #1;
    endtask

    // Offer one operand set and wait for accept; caller sits #1 after a clock edge
    task automatic offer(input int ar, ai, br, bi, wr, wi, input logic inv, scl, input string tag);
        int n = 0;
        while (!in_ready && n < 10) begin
            tick();
            n++;
        end
        check({tag, " in_ready"}, int'(in_ready), 1);
        A_real = 16'(ar); A_imag = 16'(ai);
        B_real = 16'(br); B_imag = 16'(bi);
        W_real = 16'(wr); W_imag = 16'(wi);
        inverse = inv; scale = scl; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Full butterfly up to DONE (no handshake): latency and all four results
    task automatic do_bfly(input int ar, ai, br, bi, wr, wi, input logic inv, scl,
                           input int xr, xi, yr, yi, input string tag);
        int lat = 1;
        offer(ar, ai, br, bi, wr, wi, inv, scl, tag);
        while (!out_valid && lat < 10) begin
            tick();
            lat++;
        end
        check({tag, " latency"}, lat, 4);
        check({tag, " X_real"}, X_real, xr);
        check({tag, " X_imag"}, X_imag, xi);
        check({tag, " Y_real"}, Y_real, yr);
        check({tag, " Y_imag"}, Y_imag, yi);
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        int seen;
        aclr = 1'b1; in_valid = 1'b0; inverse = 1'b0; scale = 1'b0;
        out_ready = 1'b0; ovf_clr = 1'b0;
        A_real = '0; A_imag = '0; B_real = '0; B_imag = '0; W_real = '0; W_imag = '0;

        repeat (2) tick();
        check("rst in_ready", in_ready, 0);
        check("rst out_valid", out_valid, 0);
        check("rst X_real", X_real, 0);
        check("rst Y_imag", Y_imag, 0);
        check("rst ovf", ovf, 0);
        aclr = 1'b0;
        #1;
        check("in_ready before edge", in_ready, 0);
        tick();
        check("in_ready after edge", in_ready, 1);

        do_bfly(100, 50, 20, -10, 256, 0, 1'b0, 1'b0, 120, 40, 80, 60, "identity");
        handshake();
        do_bfly(100, 50, 20, -10, 0, -256, 1'b0, 1'b0, 90, 30, 110, 70, "minus_j");
        handshake();
        do_bfly(100, 50, 20, -10, 0, -256, 1'b1, 1'b0, 110, 70, 90, 30, "minus_j_inv");
        handshake();

        do_bfly(32000, 0, 1000, 0, 256, 0, 1'b0, 1'b0, 32767, 0, 31000, 0, "sat");
        check("sat ovf", ovf, 1);
        handshake();
        tick();
        check("sat ovf sticky", ovf, 1);

        // Reset pulse while in MAC1
        offer(100, 50, 20, -10, 256, 0, 1'b0, 1'b0, "midrst");
        tick();
        aclr = 1'b1;
        #1;
        check("midrst out_valid", out_valid, 0);
        check("midrst X_real", X_real, 0);
        check("midrst ovf", ovf, 0);
        #2;
        aclr = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid) seen++;
        end
        check("midrst no out_valid", seen, 0);
        do_bfly(100, 50, 20, -10, 256, 0, 1'b0, 1'b0, 120, 40, 80, 60, "after_rst");
        handshake();

        // Set and clear in the same cycle keep ovf set; clear wins afterwards
        ovf_clr = 1'b1;
        do_bfly(32000, 0, 1000, 0, 256, 0, 1'b0, 1'b0, 32767, 0, 31000, 0, "sat_clr");
        check("set+clr ovf", ovf, 1);
        tick();
        check("clr ovf", ovf, 0);
        ovf_clr = 1'b0;
        handshake();

        do_bfly(32000, 0, 1000, 0, 256, 0, 1'b0, 1'b1, 16500, 0, 15500, 0, "scaled");
        check("scaled ovf", ovf, 0);
        handshake();

        do_bfly(0, 0, 1, 0, 128, 0, 1'b0, 1'b0, 1, 0, -1, 0, "round_pos");
        handshake();
        do_bfly(0, 0, -1, 0, 128, 0, 1'b0, 1'b0, 0, 0, 0, 0, "round_neg");
        handshake();

        // Backpressure: DONE held with stray in_valid pulses
        do_bfly(100, 50, 20, -10, 256, 0, 1'b0, 1'b0, 120, 40, 80, 60, "bp");
        A_real = 16'(7); B_real = 16'(300);
        for (int i = 0; i < 3; i++) begin
            in_valid = (i != 1);
            tick();
            check("bp out_valid", out_valid, 1);
            check("bp in_ready", in_ready, 0);
            check("bp X_real", X_real, 120);
            check("bp Y_imag", Y_imag, 60);
        end
        in_valid = 1'b0;
        handshake();
        check("bp release in_ready", in_ready, 1);
        check("bp release out_valid", out_valid, 0);
        check("bp hold X_imag", X_imag, 40);
        check("bp hold Y_real", Y_real, 80);
        tick();
        check("bp idle out_valid", out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
